comp_top: RTL and testbench

COMP_TOP -- requirements
Module: comp_top

---
 rtl/comp_pkg.sv | 23 ++
 rtl/comp_slice.sv | 23 ++
 rtl/comp_top.sv | 92 +++++++++
 tb/tb_comp_top.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/comp_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : comp_pkg
//  Description : Shared constants for the hierarchical magnitude comparator.
//                Holds the default operand width and the slice width used to
//                split the operands into 4-bit comparator slices.
//  Revision    : 1.0 - initial release
// ============================================================================
package comp_pkg;

    // Default operand width; must be a multiple of SLICE_W.
    localparam int WIDTH_DEFAULT = 16;

    // Width of one comp_slice magnitude comparator.
    localparam int SLICE_W = 4;

    // Number of slices needed to cover an operand of width w.
    function automatic int num_slices(input int w);
        return w / SLICE_W;
    endfunction

endpackage : comp_pkg
`default_nettype wire

// File: rtl/comp_slice.sv
`default_nettype none
// ============================================================================
//  Module      : comp_slice
//  Description : Purely combinational 4-bit unsigned magnitude comparator.
//  Ports       : a, b - slice operands (unsigned)
//                gt   - 1 when a > b
//                eq   - 1 when a == b
//  Revision    : 1.0 - initial release
// ============================================================================
module comp_slice
    import comp_pkg::*;
(
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b,
    output logic               gt,
    output logic               eq
);

    assign gt = (a > b);
    assign eq = (a == b);

endmodule : comp_slice
`default_nettype wire

// File: rtl/comp_top.sv
`default_nettype none
// ============================================================================
//  Module      : comp_top
//  Description : Registered signed/unsigned magnitude comparator. Operands are
//                split into 4-bit slices; per-slice GT/EQ results are merged
//                with the most significant slice dominant. Result flags are
//                registered with one cycle of latency.
//  Ports       : clk       - clock, rising edge
//                rst       - asynchronous active-high reset, clears all flags
//                in0, in1  - operands, WIDTH bits
//                is_signed - 1: two's-complement compare, 0: unsigned compare
//                GT/LT/ET  - registered in0 >, <, == in1
//  Revision    : 1.0 - initial release
// ============================================================================
module comp_top
    import comp_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    input  logic             is_signed,
    output logic             GT,
    output logic             LT,
    output logic             ET
);

    localparam int NUM_SL = num_slices(WIDTH);

    logic [WIDTH-1:0]  w_a;
    logic [WIDTH-1:0]  w_b;
    logic [NUM_SL-1:0] w_sl_gt;
    logic [NUM_SL-1:0] w_sl_eq;
    logic              w_gt;
    logic              w_eq;

    logic              gt_d, lt_d, et_d;
    logic              gt_q, lt_q, et_q;

    // Flipping the sign bit of both operands maps two's-complement ordering
    // onto unsigned ordering, so one unsigned compare serves both modes.
    // Equality is unaffected because both MSBs flip together.
    assign w_a = {in0[WIDTH-1] ^ is_signed, in0[WIDTH-2:0]};
    assign w_b = {in1[WIDTH-1] ^ is_signed, in1[WIDTH-2:0]};

    generate
        for (genvar gi = 0; gi < NUM_SL; gi++) begin : g_slice
            comp_slice u_slice (
                .a  (w_a[gi*SLICE_W +: SLICE_W]),
                .b  (w_b[gi*SLICE_W +: SLICE_W]),
                .gt (w_sl_gt[gi]),
                .eq (w_sl_eq[gi])
            );
        end
    endgenerate

    // Priority merge: walking from the LSB slice upward, a slice that is not
    // equal overrides everything below it, so the MSB slice has final say.
    always_comb begin
        w_gt = 1'b0;
        for (int i = 0; i < NUM_SL; i++) begin
            w_gt = w_sl_gt[i] | (w_sl_eq[i] & w_gt);
        end
    end

    assign w_eq = &w_sl_eq;

    assign gt_d = w_gt;
    assign et_d = w_eq;
    assign lt_d = ~w_gt & ~w_eq;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gt_q <= 1'b0;
            lt_q <= 1'b0;
            et_q <= 1'b0;
        end else begin
            gt_q <= gt_d;
            lt_q <= lt_d;
            et_q <= et_d;
        end
    end

    assign GT = gt_q;
    assign LT = lt_q;
    assign ET = et_q;

endmodule : comp_top
`default_nettype wire

// File: tb/tb_comp_top.sv
`default_nettype none
// ============================================================================
//  Module      : tb_comp_top
//  Description : Self-checking bench for comp_top. Stimulus pushes the
//                expected flags into a scoreboard queue; a monitor pops one
//                entry after every rising edge and compares GT/LT/ET.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_comp_top;

    localparam int W = 16;

    typedef struct {
        logic [2:0] flags;   // {GT, LT, ET}
        string      name;
    } exp_t;

    logic         clk;
    logic         rst;
    logic [W-1:0] in0;
    logic [W-1:0] in1;
    logic         is_signed;
    logic         GT, LT, ET;

    exp_t sb[$];
    int   total;
    int   bad;

    comp_top #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in0       (in0),
        .in1       (in1),
        .is_signed (is_signed),
        .GT        (GT),
        .LT        (LT),
        .ET        (ET)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: interpret operands as plain integers and compare them.
    function automatic logic [2:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic s);
        longint va;
        longint vb;
        va = longint'(a);
        vb = longint'(b);
        if (s) begin
            if (va >= (longint'(1) << (W-1))) va = va - (longint'(1) << W);
            if (vb >= (longint'(1) << (W-1))) vb = vb - (longint'(1) << W);
        end
        return {va > vb, va < vb, va == vb};
    endfunction

    task automatic check(input string nm, input logic [2:0] got, input logic [2:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: GT/LT/ET got %b want %b (in0=%h in1=%h signed=%b)",
                     nm, got, want, in0, in1, is_signed);
        end
    endtask

    // Monitor: each edge after a push presents the registered response.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (!rst && sb.size() > 0) begin
            e = sb.pop_front();
            check(e.name, {GT, LT, ET}, e.flags);
            total++;
            if ((GT + LT + ET) != 1) begin
                bad++;
                $display("FAIL onehot_%s: GT/LT/ET got %b want exactly one set",
                         e.name, {GT, LT, ET});
            end
        end
    end

    task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic s, input string nm);
        @(negedge clk);
        in0       = a;
        in1       = b;
        is_signed = s;
        sb.push_back('{model(a, b, s), nm});
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 50) begin
            @(posedge clk);
            #2;
            n++;
        end
        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: queue depth got %0d want 0", sb.size());
            sb.delete();
        end
    endtask

    initial begin
        logic [W-1:0] ext[4];
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         s;

        total     = 0;
        bad       = 0;
        rst       = 1'b1;
        in0       = '0;
        in1       = '0;
        is_signed = 1'b0;
        ext[0]    = 16'h0000;
        ext[1]    = 16'hFFFF;
        ext[2]    = 16'h8000;
        ext[3]    = 16'h7FFF;

        // Reset state, before and across a clock edge.
        #3;
        check("reset_state", {GT, LT, ET}, 3'b000);
        @(posedge clk);
        #1;
        check("reset_hold_edge", {GT, LT, ET}, 3'b000);

        @(negedge clk);
        rst = 1'b0;

        // Unsigned directed cases.
        drive(16'd5, 16'd3,  1'b0, "u_5_gt_3");
        drive(16'd3, 16'd10, 1'b0, "u_3_lt_10");
        drive(16'd7, 16'd7,  1'b0, "u_7_eq_7");

        // Signed directed cases.
        drive(16'hFFFF, 16'd5,    1'b1, "s_m1_lt_5");
        drive(16'd5,    16'hFFFF, 1'b1, "s_5_gt_m1");
        drive(16'hFFFE, 16'hFFFB, 1'b1, "s_m2_gt_m5");
        drive(16'hFFFB, 16'hFFFE, 1'b1, "s_m5_lt_m2");
        drive(16'd10,   16'd2,    1'b1, "s_10_gt_2");

        // Mode contrast on identical operands.
        drive(16'hFFFF, 16'd5, 1'b0, "mode_unsigned");
        drive(16'hFFFF, 16'd5, 1'b1, "mode_signed");

        // Boundaries.
        drive(16'h8000, 16'h7FFF, 1'b0, "b_8000_7fff_u");
        drive(16'h8000, 16'h7FFF, 1'b1, "b_8000_7fff_s");
        drive(16'h0000, 16'hFFFF, 1'b0, "b_0000_ffff_u");
        drive(16'h0000, 16'hFFFF, 1'b1, "b_0000_ffff_s");
        for (int i = 0; i < 3; i++) begin
            drive(ext[i], ext[i], 1'b0, "b_eq_ext_u");
            drive(ext[i], ext[i], 1'b1, "b_eq_ext_s");
        end

        // Latency: operands change mid-cycle, flags must hold until the edge.
        drive(16'd5, 16'd3, 1'b0, "lat_a");
        drive(16'd3, 16'd5, 1'b0, "lat_b");
        #1;
        check("lat_hold", {GT, LT, ET}, 3'b100);
        wait_drain();

        // Asynchronous reset while GT is set.
        drive(16'h1234, 16'h0012, 1'b0, "pre_rst");
        wait_drain();
        #1;
        rst = 1'b1;
        #1;
        check("rst_async_clear", {GT, LT, ET}, 3'b000);
        @(posedge clk);
        #1;
        check("rst_hold_edge", {GT, LT, ET}, 3'b000);
        @(negedge clk);
        in0       = 16'h8000;
        in1       = 16'h7FFF;
        is_signed = 1'b1;
        rst       = 1'b0;
        sb.push_back('{model(16'h8000, 16'h7FFF, 1'b1), "post_rst_first"});

        // Randomized sweep, both modes, biased toward equal and extreme values.
        for (int i = 0; i < 600; i++) begin
            s = 1'(($urandom() & 32'h1));
            a = W'($urandom());
            case ($urandom_range(0, 5))
                0: b = a;
                1: b = a ^ 16'h8000;
                2: begin a = ext[$urandom_range(0, 3)]; b = ext[$urandom_range(0, 3)]; end
                3: b = {a[W-1:4], 4'($urandom())};
                default: b = W'($urandom());
            endcase
            drive(a, b, s, "rand");
        end

        wait_drain();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule : tb_comp_top
`default_nettype wire
